// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory initiator and fetch-PC logic.
package mem_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 8;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic INST_REGION  = 1'b0;
  localparam logic DATA_REGION  = 1'b1;
  localparam int   REGION_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

  // Next byte address, wrapping inside the region selected by the top address bit.
  function automatic logic [DEF_ADDR_W-1:0] region_incr(input logic [DEF_ADDR_W-1:0] a);
    return {a[DEF_ADDR_W-1], a[DEF_ADDR_W-2:0] + (DEF_ADDR_W-1)'(1)};
  endfunction

  // Fetches must target the instruction region, loads/stores the data region.
  function automatic logic req_legal(input logic [1:0] op, input logic [DEF_ADDR_W-1:0] a);
    logic region;
    region = a[DEF_ADDR_W-1];
    case (op)
      OP_FETCH: return region == INST_REGION;
      OP_LOAD,
      OP_STORE: return region == DATA_REGION;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// 16-bit request initiator that splits each access into two byte cycles on the memory port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; latches op/addr/wdata on accept
// LO      | low byte access at A
// HI      | high byte access at region_incr(A)
// RESP    | one-cycle response pulse, error flag reported
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_w_en,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  mem_state_e          state, state_nx;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic                err_q;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   hi_addr;
  logic                accept;
  logic                legal;
  logic                is_store;

  assign accept   = (state == ST_IDLE) && req_valid;
  assign legal    = req_legal(req_op, req_addr);
  assign is_store = (op_q == OP_STORE);
  assign hi_addr  = region_incr(addr_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Request latch on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= !legal;
    end
  end

  // Response data: cleared when no read result will follow, else filled byte by byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
    end else begin
      if (accept && (!legal || req_op == OP_STORE)) rsp_data <= '0;
      if (state == ST_LO && !is_store) rsp_data[DATA_W-1:0]        <= mem_rdata;
      if (state == ST_HI && !is_store) rsp_data[2*DATA_W-1:DATA_W] <= mem_rdata;
    end
  end

  // Remembers the last driven memory address so it holds in IDLE and RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 last_addr <= '0;
    else if (state == ST_LO)  last_addr <= addr_q;
    else if (state == ST_HI)  last_addr <= hi_addr;
  end

  // Next state and outputs; write strobes decode only registered state.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_addr  = last_addr;
    mem_w_en  = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = legal ? ST_LO : ST_RESP;
      end
      ST_LO: begin
        mem_addr = addr_q;
        if (is_store) begin
          mem_w_en  = 1'b1;
          mem_wdata = wdata_q[DATA_W-1:0];
        end
        state_nx = ST_HI;
      end
      ST_HI: begin
        mem_addr = hi_addr;
        if (is_store) begin
          mem_w_en  = 1'b1;
          mem_wdata = wdata_q[2*DATA_W-1:DATA_W];
        end
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator for the shared 32×8 instruction/data memory. It accepts 16-bit fetch, load and store requests from the core on a valid/ready handshake and splits each request into two byte accesses on the memory port (combinational read, synchronous write). It also enforces the region split: bytes 0–15 are instructions and bytes 16–31 are data. Sits between the multicycle datapath controller and the memory.

## Interface
Parameters:
- ADDR_W, 5, memory byte address width
- DATA_W, 8, memory byte width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_op  in  2  00 fetch, 01 load, 10 store, 11 reserved
- req_addr  in  5  byte address of low byte
- req_wdata  in  16  store data, little-endian
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  16  fetch/load result; 0 for store or error
- rsp_err  out  1  qualified by rsp_valid; region or op violation
- mem_addr  out  5  memory address
- mem_w_en  out  1  memory write enable
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte (combinational from mem_addr)

## Operation
- FSM states: IDLE, LO, HI, RESP.
- IDLE: req_ready=1. When req_valid is high at a clock edge, latch op, addr and wdata.
  - Legal request: go to LO.
  - Illegal request: set the error flag and go to RESP directly, with no memory access.
- Illegal means: op=11; fetch with addr[4]=1; load/store with addr[4]=0.
- LO:
  - mem_addr = A.
  - Fetch/load: capture mem_rdata into rsp_data[7:0] at the edge.
  - Store: mem_w_en=1, mem_wdata=wdata[7:0].
  - Go to HI.
- HI:
  - mem_addr = {A[4], A[3:0]+1}. The increment wraps inside the region: 15→0, 31→16.
  - Fetch/load: capture rsp_data[15:8].
  - Store: mem_w_en=1, mem_wdata=wdata[15:8].
  - Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, rsp_err = error flag, then go to IDLE.
- mem_w_en is 0 in IDLE and RESP, and 0 in every state for fetch and load.
- mem_addr holds the last driven value in IDLE and RESP.
- rsp_data holds its value until the next capture. It is cleared to 0 on accept of a store or an illegal request.
- req_valid while not in IDLE is ignored; the requester holds the request until it sees req_ready.
- Odd (unaligned) addresses are legal.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, mem_addr=0, mem_w_en=0, mem_wdata=0.
- Legal request accepted at edge 0:
  - LO during cycle 1; memory write or read capture at edge 1.
  - HI during cycle 2; write or capture at edge 2.
  - rsp_valid high during cycle 3; req_ready high again in cycle 4.
- Throughput: one request per 4 cycles.
- Illegal request accepted at edge 0: rsp_valid=1 and rsp_err=1 in cycle 1; req_ready high in cycle 2.
- Reset asserted mid-operation:
  - Immediate return to the reset values, with no response.
  - A store interrupted after edge 1 leaves only the low byte written. This is accepted behaviour and the requester must reissue.
- mem_w_en changes only on clock edges, driven from registered state, so a write never straddles two addresses.

## Structure
- Shared package mem_pkg holds:
  - op encodings: OP_FETCH, OP_LOAD, OP_STORE
  - state enum
  - region constants: INST_REGION=0, DATA_REGION=1, REGION_BYTES=16
  - ADDR_W and DATA_W defaults
- No sub-module; single FSM plus datapath registers.
- The region-wrapping address increment is a package function, region_incr, reused by the fetch-PC logic.

## Test plan
- Fetch at 0x02 with mem[2]=0x34, mem[3]=0x12 -> rsp_valid in cycle 3, rsp_data=0x1234, rsp_err=0, mem_w_en never high.
- Store 0xBEEF at 0x1F -> mem_w_en on edges 1 and 2; mem[31]=0xEF, mem[16]=0xBE (wrap); rsp_err=0; rsp_data=0.
- Load at 0x0F (instruction region) -> no memory access, rsp_valid and rsp_err=1 in cycle 1; op=11 behaves the same.
- Fetch at 0x0F with mem[15]=0xAA, mem[0]=0x55 -> rsp_data=0x55AA.
- Back-to-back requests with req_valid held high -> second accepted exactly 4 cycles after the first; req_ready low during cycles 1–3.
- rst asserted during HI of a store to 0x10 -> outputs at reset values immediately, no rsp_valid, mem[16] written, mem[17] unchanged.
